// File: rtl/ext_nand_page_read_seq.sv
// External-NAND page-read sequencer: 00h, 5 address cycles, 30h,
// tWB/R-B wait, then hands off to the data reader until it completes.
// Ports: CLK/RST_N; START/PAGE_ADDR request; BUSY/DONE/TIMEOUT status;
// CE_N/CLE/ALE/WE_N/IO_OUT/IO_OE NAND bus; RB ready/busy;
// RD_ENA/RD_COMPLT data-reader handshake.
module ext_nand_page_read_seq #(
    parameter int ROW_W   = 24,
    parameter int TWB_CYC = 4,
    parameter int TO_CYC  = 65535
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [ROW_W-1:0] PAGE_ADDR,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic             CE_N,
    output logic             CLE,
    output logic             ALE,
    output logic             WE_N,
    output logic [7:0]       IO_OUT,
    output logic             IO_OE,
    input  logic             RB,
    output logic             RD_ENA,
    input  logic             RD_COMPLT
);

    typedef enum logic [2:0] {
        IDLE, CMD1, ADDR, CMD2,
        WAIT_WB, WAIT_RDY, READ, FINISH
    } state_t;

    localparam logic [15:0] TWB_LAST = 16'(TWB_CYC - 1);
    localparam logic [15:0] TO_LAST  = 16'(TO_CYC - 1);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [2:0]  byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        rb_s1_q, rb_s2_q;
    logic [23:0] row_ext;
    logic [7:0]  addr_byte;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            byte_q  <= 3'd0;
            cnt_q   <= 16'd0;
            addr_q  <= 24'd0;
            err_q   <= 1'b0;
            rb_s1_q <= 1'b0;
            rb_s2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            rb_s1_q <= RB;
            rb_s2_q <= rb_s1_q;
        end
    end

    // Row address zero-extended to the 3 row bytes the device expects.
    always_comb begin
        row_ext = '0;
        row_ext[ROW_W-1:0] = PAGE_ADDR;
    end

    // Column bytes are fixed 0; row bytes go LSB first.
    always_comb begin
        unique case (byte_q)
            3'd2:    addr_byte = addr_q[7:0];
            3'd3:    addr_byte = addr_q[15:8];
            3'd4:    addr_byte = addr_q[23:16];
            default: addr_byte = 8'h00;
        endcase
    end

    assign BUSY = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        CE_N    = 1'b1;
        CLE     = 1'b0;
        ALE     = 1'b0;
        WE_N    = 1'b1;
        IO_OUT  = 8'h00;
        IO_OE   = 1'b0;
        RD_ENA  = 1'b0;
        DONE    = 1'b0;
        TIMEOUT = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d  = row_ext;
                    phase_d = 1'b0;
                    state_d = CMD1;
                end
            end
            CMD1: begin
                CE_N    = 1'b0;
                CLE     = 1'b1;
                IO_OE   = 1'b1;
                IO_OUT  = 8'h00;
                WE_N    = phase_q;
                phase_d = ~phase_q;
                if (phase_q) begin
                    byte_d  = 3'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                CE_N    = 1'b0;
                ALE     = 1'b1;
                IO_OE   = 1'b1;
                IO_OUT  = addr_byte;
                WE_N    = phase_q;
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (byte_q == 3'd4) begin
                        byte_d  = 3'd0;
                        state_d = CMD2;
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end
            end
            CMD2: begin
                CE_N    = 1'b0;
                CLE     = 1'b1;
                IO_OE   = 1'b1;
                IO_OUT  = 8'h30;
                WE_N    = phase_q;
                phase_d = ~phase_q;
                if (phase_q) begin
                    cnt_d   = 16'd0;
                    state_d = WAIT_WB;
                end
            end
            WAIT_WB: begin
                CE_N = 1'b0;
                if (cnt_q == TWB_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = WAIT_RDY;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_RDY: begin
                CE_N = 1'b0;
                // Ready is checked first so it wins on the last poll.
                if (rb_s2_q) begin
                    cnt_d   = 16'd0;
                    state_d = READ;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = 16'd0;
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            READ: begin
                CE_N   = 1'b0;
                RD_ENA = 1'b1;
                // cnt_q==0 marks the first READ cycle, where the
                // reader's completion flag is still stale.
                cnt_d  = 16'd1;
                if (cnt_q != 16'd0 && RD_COMPLT) begin
                    cnt_d   = 16'd0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                DONE    = 1'b1;
                TIMEOUT = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ext_nand_page_read_seq.sv
// Self-checking bench for ext_nand_page_read_seq: vector table,
// randomized transactions against a timing model, reset corner case.
module tb_ext_nand_page_read_seq;

    localparam int TWB = 4;
    localparam int TO  = 100;

    logic        CLK, RST_N, START, RB, RD_COMPLT;
    logic [23:0] PAGE_ADDR;
    logic        BUSY, DONE, TIMEOUT, CE_N, CLE, ALE, WE_N;
    logic        IO_OE, RD_ENA;
    logic [7:0]  IO_OUT;

    int checks = 0;
    int errors = 0;

    ext_nand_page_read_seq #(
        .ROW_W(24), .TWB_CYC(TWB), .TO_CYC(TO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .PAGE_ADDR(PAGE_ADDR), .BUSY(BUSY), .DONE(DONE),
        .TIMEOUT(TIMEOUT), .CE_N(CE_N), .CLE(CLE), .ALE(ALE),
        .WE_N(WE_N), .IO_OUT(IO_OUT), .IO_OE(IO_OE), .RB(RB),
        .RD_ENA(RD_ENA), .RD_COMPLT(RD_COMPLT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] addr;
        int          busy;
        int          d;
        bit          stale;
        bit          poke;
        bit          exp_to;
        int          exp_rd;
        int          exp_gap;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {CE_N, CLE, ALE, WE_N, IO_OUT, IO_OE,
                RD_ENA, BUSY, DONE, TIMEOUT};
    endfunction

    // Model: bus of 7 bytes; RB low 'busy' cycles from the first
    // post-bus cycle, seen 2 cycles later; reader raises COMPLT
    // after 'd' cycles of RD_ENA, ignored on the first READ cycle.
    function automatic vec_t model(input logic [23:0] a, input int b,
                                   input int d, input bit st,
                                   input bit pk);
        vec_t v;
        int rdy;
        v.addr = a; v.busy = b; v.d = d; v.stale = st; v.poke = pk;
        rdy = b + 3;
        v.exp_to = (rdy > TWB + TO);
        if (v.exp_to) begin
            v.exp_gap = TWB + TO;
            v.exp_rd  = 0;
        end else begin
            v.exp_gap = (rdy > TWB + 1) ? rdy : TWB + 1;
            v.exp_rd  = (st || d == 0) ? 2 : d + 1;
        end
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic run_txn(input vec_t v);
        logic [9:0] bq [$];
        logic [9:0] eb [7];
        int ioe_n = 0, gap = 0, rd_n = 0;
        int lowrun = 0, maxlow = 0;
        bit done_seen = 0, to_seen = 0, ce_bad = 0;
        bit ce_done = 0, post_bad = 0;
        eb[0] = {2'b10, 8'h00};
        eb[1] = {2'b01, 8'h00};
        eb[2] = {2'b01, 8'h00};
        eb[3] = {2'b01, v.addr[7:0]};
        eb[4] = {2'b01, v.addr[15:8]};
        eb[5] = {2'b01, v.addr[23:16]};
        eb[6] = {2'b10, 8'h30};
        @(negedge CLK);
        START = 1'b1;
        PAGE_ADDR = v.addr;
        RD_COMPLT = v.stale;
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (DONE) begin
                done_seen = 1;
                to_seen = TIMEOUT;
                ce_done = CE_N;
                break;
            end
            if (CE_N !== 1'b0) ce_bad = 1;
            if (!WE_N) begin
                bq.push_back({CLE, ALE, IO_OUT});
                lowrun++;
                if (lowrun > maxlow) maxlow = lowrun;
            end else begin
                lowrun = 0;
            end
            if (IO_OE) ioe_n++;
            if (!IO_OE && !RD_ENA && ioe_n > 0 && rd_n == 0) begin
                gap++;
                RB = (gap >= 1 + v.busy);
            end
            if (RD_ENA) begin
                rd_n++;
                if (rd_n > v.d) RD_COMPLT = 1'b1;
            end
            if (v.poke && ALE && !WE_N && bq.size() == 3) begin
                START = 1'b1;
                PAGE_ADDR = ~v.addr;
            end
            if (v.poke && RD_ENA && rd_n == 1) START = 1'b1;
        end
        RD_COMPLT = 1'b0;
        RB = 1'b1;
        START = 1'b0;
        chk("done_seen", 32'(done_seen), 1);
        chk("we_pulses", bq.size(), 7);
        chk("we_low_len", maxlow, 1);
        for (int i = 0; i < 7 && i < bq.size(); i++)
            chk($sformatf("byte%0d", i), 32'(bq[i]), 32'(eb[i]));
        chk("io_oe_cycles", ioe_n, 14);
        chk("wait_cycles", gap, v.exp_gap);
        chk("rd_ena_cycles", rd_n, v.exp_rd);
        chk("timeout", 32'(to_seen), 32'(v.exp_to));
        chk("ce_low_busy", 32'(ce_bad), 0);
        chk("ce_high_done", 32'(ce_done), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (BUSY || DONE || !CE_N) post_bad = 1;
        end
        chk("idle_after_done", 32'(post_bad), 0);
    endtask

    initial begin
        logic [16:0] rst_exp;
        int nb;
        rst_exp = {1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'b00000};
        RST_N = 1'b0;
        START = 1'b0;
        RB = 1'b1;
        RD_COMPLT = 1'b0;
        PAGE_ADDR = '0;

        vt[0] = '{24'h012345, 20, 3, 1'b0, 1'b0, 1'b0, 4, 23};
        vt[1] = '{24'hA5A5A5, 102, 0, 1'b0, 1'b0, 1'b1, 0, 104};
        vt[2] = '{24'h00FFEE, 101, 1, 1'b0, 1'b0, 1'b0, 2, 104};
        vt[3] = '{24'h123456, 0, 2, 1'b0, 1'b0, 1'b0, 3, 5};
        vt[4] = '{24'hABCDEF, 5, 2, 1'b0, 1'b1, 1'b0, 3, 8};
        vt[5] = '{24'h0F0F0F, 10, 0, 1'b1, 1'b0, 1'b0, 2, 13};

        idle(3);
        chk("reset_outs", 32'(outs()), 32'(rst_exp));
        RST_N = 1'b1;
        idle(3);
        chk("idle_outs", 32'(outs()), 32'(rst_exp));

        for (int i = 0; i < 6; i++) begin
            run_txn(vt[i]);
            idle(2);
        end

        // Reset while the 3rd address byte is on the bus.
        @(negedge CLK);
        START = 1'b1;
        PAGE_ADDR = 24'h777777;
        nb = 0;
        for (int i = 0; i < 50 && nb < 4; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (!WE_N) nb++;
        end
        chk("rst_reach_addr", nb, 4);
        chk("rst_mid_ale", 32'(ALE), 1);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(outs()), 32'(rst_exp));
        @(negedge CLK);
        chk("rst_hold_outs", 32'(outs()), 32'(rst_exp));
        RST_N = 1'b1;
        idle(3);
        run_txn(model(24'h012345, 20, 3, 1'b0, 1'b0));
        idle(2);

        for (int i = 0; i < 30; i++) begin
            int b;
            b = ($urandom_range(0, 7) == 0) ?
                int'($urandom_range(95, 110)) :
                int'($urandom_range(0, 40));
            run_txn(model($urandom, b, $urandom_range(0, 5),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1))));
            idle($urandom_range(2, 5));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
